trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap and `mret` sequencer for the core. It sits between writeback, the CSR unit and fetch. When writeback reports an exception, a pending enabled interrupt, or an `mret`, it stalls and flushes the pipeline and sequences the CSR state updates one write per cycle through the CSR write port. It then hands the new PC to fetch with a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, default 32: data and PC width.

Ports:
- `clk`  in  1  the single clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `wb_retire`  in  1  an instruction retires this cycle.
- `wb_next_pc`  in  XLEN  PC of the next instruction to execute.
- `wb_exception`  in  1  the retiring slot faulted.
- `wb_ecause`  in  4  exception code.
- `wb_epc`  in  XLEN  PC of the faulting instruction.
- `wb_tval`  in  XLEN  trap value.
- `wb_mret`  in  1  the retiring instruction is `mret`.
- `irq_pending`  in  3  {eip, sip, tip} from the CSR unit, already masked by `mie`.
- `mstatus`  in  XLEN  current `mstatus`.
- `trap_vector`  in  XLEN  from the CSR unit.
- `mret_vector`  in  XLEN  from the CSR unit.
- `csr_we`  out  1  CSR write enable.
- `csr_waddr`  out  12  CSR write address.
- `csr_wdata`  out  XLEN  CSR write data.
- `busy`  out  1  pipeline stall.
- `flush`  out  1  one-cycle pipeline flush.
- `trap_taken`  out  1  one-cycle pulse at trap commit.
- `redirect_valid`  out  1  new PC offered to fetch.
- `redirect_pc`  out  XLEN  the new PC.
- `redirect_ready`  in  1  fetch accepts the redirect.

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, M_MSTAT, REDIRECT.
- IDLE, events in priority order:
  - `wb_exception`: latch epc = `wb_epc`, cause = {0, `wb_ecause`}, tval = `wb_tval`; go to W_MEPC.
  - Interrupt: requires `wb_retire`, `mstatus[3]` (MIE) = 1 and `irq_pending` ≠ 0. Latch epc = `wb_next_pc`, tval = 0, cause = {1, code}, where code is MEI=11, then MSI=3, then MTI=7 in that priority. Go to W_MEPC.
  - `wb_mret` with `wb_retire`: go to M_MSTAT.
- CSR write per state:
  - W_MEPC writes 0x341 ← epc.
  - W_MCAUSE writes 0x342 ← cause.
  - W_MTVAL writes 0x343 ← tval.
  - W_MSTAT writes 0x300 ← `mstatus` with MPIE (bit 7) = old MIE, MIE = 0, MPP (bits 12:11) = 2'b11.
  - M_MSTAT writes 0x300 ← `mstatus` with MIE = old MPIE, MPIE = 1, MPP = 2'b11.
- Transitions:
  - Trap path: W_MEPC → W_MCAUSE → W_MTVAL → W_MSTAT → REDIRECT.
  - `mret` path: M_MSTAT → REDIRECT.
  - REDIRECT → IDLE on `redirect_ready`.
- `redirect_pc` is sampled on entry to REDIRECT:
  - Trap path takes `trap_vector`. `mcause` is already written, so vectored mode resolves correctly.
  - `mret` path takes `mret_vector`.
- `trap_taken` pulses on the W_MSTAT cycle.
- Writeback inputs are ignored outside IDLE.

## Timing
- Reset value of every output is 0; the state resets to IDLE. `reset_n` asserted mid-sequence aborts it, and no further CSR writes occur.
- All outputs are registered. For an event sampled at cycle T:
  - `flush` = 1 at T+1 only.
  - `busy` = 1 from T+1 until the cycle after the redirect handshake.
  - Trap: CSR writes at T+1..T+4, `redirect_valid` from T+5.
  - `mret`: CSR write at T+1, `redirect_valid` from T+2.
- `redirect_valid` and `redirect_pc` stay stable until `redirect_ready`. Handshake in cycle H: IDLE at H+1, with `busy` = 0 and `redirect_valid` = 0.
- Simultaneous exception and interrupt: the exception wins, and the interrupt is re-evaluated afterwards.
- Simultaneous exception and `mret`: the exception wins.
- An interrupt arriving with MIE = 0 is not taken.

## Configuration
- `TRAP_MTVAL_EN`:
  - Defined: W_MTVAL is present.
  - Undefined: W_MTVAL is removed, `mtval` is never written, and trap latency shrinks by one (`redirect_valid` from T+4). `wb_tval` is unused.

## Structure
- Shared package `core_pkg`:
  - CSR address constants (MSTATUS, MEPC, MCAUSE, MTVAL).
  - Interrupt cause codes.
  - `mstatus` bit-index constants.
  - State enum `trap_state_t`.
- One sub-module, `irq_prioritizer`: combinational, 3-bit pending in, {valid, cause code} out.

## Test plan
- `wb_exception`=1, `wb_ecause`=2, `wb_epc`=0x100, `wb_tval`=0xDEAD, `mstatus`=0x8 → writes 0x341←0x100, 0x342←2, 0x343←0xDEAD, 0x300←0x1880; `redirect_pc`=`trap_vector` at T+5.
- `irq_pending`=3'b011 (sip, tip), MIE=1, retire with `wb_next_pc`=0x204 → `mcause`=0x80000003, `mepc`=0x204, `mtval`=0.
- Pending interrupt with MIE=0 → no writes; `busy` stays 0.
- `wb_mret` with `mstatus`=0x1880 → single write 0x300←0x1888; `redirect_pc`=`mret_vector` at T+2.
- `redirect_ready` held low for 5 cycles → `redirect_valid`, `redirect_pc` and `busy` are held; the state returns to IDLE one cycle after ready.
- `reset_n` asserted at T+2 of a trap → all outputs 0; no further writes after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the machine-mode trap sequencer:
// CSR addresses, interrupt cause codes, mstatus bit positions and
// the trap sequencer state encoding.
package core_pkg;

  localparam int unsigned CSR_ADDR_W   = 12;
  localparam int unsigned CAUSE_CODE_W = 4;

  // Machine-mode CSR write addresses
  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL   = 12'h343;

  // Interrupt cause codes (interrupt flag is carried separately in mcause MSB)
  localparam logic [CAUSE_CODE_W-1:0] IRQ_CODE_MEI = 4'd11;
  localparam logic [CAUSE_CODE_W-1:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [CAUSE_CODE_W-1:0] IRQ_CODE_MTI = 4'd7;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_MEPC   = 3'd1,
    W_MCAUSE = 3'd2,
    W_MTVAL  = 3'd3,
    W_MSTAT  = 3'd4,
    M_MSTAT  = 3'd5,
    REDIRECT = 3'd6
  } trap_state_t;

endpackage

// File: rtl/irq_prioritizer.sv
// Fixed-priority interrupt selector: MEI over MSI over MTI.
// Ports:
//   pending  in  3  {eip, sip, tip}, already masked by mie
//   valid_c  out 1  any interrupt pending (combinational)
//   code_c   out 4  cause code of the winning interrupt (combinational)
module irq_prioritizer
  import core_pkg::*;
(
  input  logic [2:0]              pending,
  output logic                    valid_c,
  output logic [CAUSE_CODE_W-1:0] code_c
);

  // Priority encode; code is don't-care when nothing is pending
  always_comb begin
    valid_c = |pending;
    code_c  = IRQ_CODE_MEI;
    if (pending[2]) begin
      code_c = IRQ_CODE_MEI;
    end else if (pending[1]) begin
      code_c = IRQ_CODE_MSI;
    end else if (pending[0]) begin
      code_c = IRQ_CODE_MTI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap / mret sequencer. On an exception, an enabled pending
// interrupt or a retiring mret it stalls and flushes the pipeline, issues
// the CSR updates one per cycle, then offers the new PC to fetch.
// Build option: define TRAP_MTVAL_EN to include the mtval write state;
// without it mtval is never written and trap latency is one cycle shorter.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   wb_retire, wb_next_pc        retiring slot and its successor PC
//   wb_exception, wb_ecause,
//   wb_epc, wb_tval              exception report from writeback
//   wb_mret                      retiring instruction is mret
//   irq_pending                  {eip, sip, tip}, masked by mie
//   mstatus                      current mstatus value
//   trap_vector, mret_vector     target PCs from the CSR unit
//   csr_we, csr_waddr, csr_wdata CSR write port
//   busy, flush, trap_taken      pipeline control / trap commit pulse
//   redirect_valid, redirect_pc,
//   redirect_ready               new-PC handshake with fetch
module trap_sequencer
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_retire,
  input  logic [XLEN-1:0]       wb_next_pc,
  input  logic                  wb_exception,
  input  logic [3:0]            wb_ecause,
  input  logic [XLEN-1:0]       wb_epc,
  input  logic [XLEN-1:0]       wb_tval,
  input  logic                  wb_mret,
  input  logic [2:0]            irq_pending,
  input  logic [XLEN-1:0]       mstatus,
  input  logic [XLEN-1:0]       trap_vector,
  input  logic [XLEN-1:0]       mret_vector,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  busy,
  output logic                  flush,
  output logic                  trap_taken,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  input  logic                  redirect_ready
);

  trap_state_t state, state_n;

  logic [XLEN-1:0]       cause_q, cause_n;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0]       tval_q, tval_n;
`else
  logic                  unused_tval;
  assign unused_tval = ^wb_tval;
`endif

  logic                  csr_we_n;
  logic [CSR_ADDR_W-1:0] csr_waddr_n;
  logic [XLEN-1:0]       csr_wdata_n;
  logic                  busy_n;
  logic                  flush_n;
  logic                  trap_taken_n;
  logic                  redirect_valid_n;
  logic [XLEN-1:0]       redirect_pc_n;

  logic                    irq_valid_c;
  logic [CAUSE_CODE_W-1:0] irq_code_c;
  logic                    irq_take_c;
  logic [XLEN-1:0]         trap_mstatus_c;
  logic [XLEN-1:0]         mret_mstatus_c;

  irq_prioritizer u_irq_prioritizer (
    .pending (irq_pending),
    .valid_c (irq_valid_c),
    .code_c  (irq_code_c)
  );

  // Interrupts are only taken at an instruction boundary with MIE set
  assign irq_take_c = wb_retire && mstatus[MSTATUS_MIE] && irq_valid_c;

  // mstatus images written on trap entry and on mret
  always_comb begin
    trap_mstatus_c = mstatus;
    trap_mstatus_c[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    trap_mstatus_c[MSTATUS_MIE]  = 1'b0;
    trap_mstatus_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mret_mstatus_c = mstatus;
    mret_mstatus_c[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    mret_mstatus_c[MSTATUS_MPIE] = 1'b1;
    mret_mstatus_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Next state and next registered outputs; outputs for a state are
  // computed on entry so they appear in the same cycle as the state.
  always_comb begin
    state_n          = state;
    cause_n          = cause_q;
`ifdef TRAP_MTVAL_EN
    tval_n           = tval_q;
`endif
    csr_we_n         = 1'b0;
    csr_waddr_n      = '0;
    csr_wdata_n      = '0;
    busy_n           = 1'b0;
    flush_n          = 1'b0;
    trap_taken_n     = 1'b0;
    redirect_valid_n = 1'b0;
    redirect_pc_n    = redirect_pc;

    unique case (state)
      IDLE: begin
        if (wb_exception) begin
          cause_n     = XLEN'(wb_ecause);
`ifdef TRAP_MTVAL_EN
          tval_n      = wb_tval;
`endif
          state_n     = W_MEPC;
          csr_we_n    = 1'b1;
          csr_waddr_n = CSR_MEPC;
          csr_wdata_n = wb_epc;
          busy_n      = 1'b1;
          flush_n     = 1'b1;
        end else if (irq_take_c) begin
          cause_n     = {1'b1, (XLEN-1)'(irq_code_c)};
`ifdef TRAP_MTVAL_EN
          tval_n      = '0;
`endif
          state_n     = W_MEPC;
          csr_we_n    = 1'b1;
          csr_waddr_n = CSR_MEPC;
          csr_wdata_n = wb_next_pc;
          busy_n      = 1'b1;
          flush_n     = 1'b1;
        end else if (wb_mret && wb_retire) begin
          state_n     = M_MSTAT;
          csr_we_n    = 1'b1;
          csr_waddr_n = CSR_MSTATUS;
          csr_wdata_n = mret_mstatus_c;
          busy_n      = 1'b1;
          flush_n     = 1'b1;
        end
      end

      W_MEPC: begin
        state_n     = W_MCAUSE;
        csr_we_n    = 1'b1;
        csr_waddr_n = CSR_MCAUSE;
        csr_wdata_n = cause_q;
        busy_n      = 1'b1;
      end

`ifdef TRAP_MTVAL_EN
      W_MCAUSE: begin
        state_n     = W_MTVAL;
        csr_we_n    = 1'b1;
        csr_waddr_n = CSR_MTVAL;
        csr_wdata_n = tval_q;
        busy_n      = 1'b1;
      end

      W_MTVAL: begin
        state_n      = W_MSTAT;
        csr_we_n     = 1'b1;
        csr_waddr_n  = CSR_MSTATUS;
        csr_wdata_n  = trap_mstatus_c;
        busy_n       = 1'b1;
        trap_taken_n = 1'b1;
      end
`else
      W_MCAUSE: begin
        state_n      = W_MSTAT;
        csr_we_n     = 1'b1;
        csr_waddr_n  = CSR_MSTATUS;
        csr_wdata_n  = trap_mstatus_c;
        busy_n       = 1'b1;
        trap_taken_n = 1'b1;
      end
`endif

      // mcause is already committed here, so a vectored trap_vector is valid
      W_MSTAT: begin
        state_n          = REDIRECT;
        busy_n           = 1'b1;
        redirect_valid_n = 1'b1;
        redirect_pc_n    = trap_vector;
      end

      M_MSTAT: begin
        state_n          = REDIRECT;
        busy_n           = 1'b1;
        redirect_valid_n = 1'b1;
        redirect_pc_n    = mret_vector;
      end

      // Hold the offer (pc is not resampled) until fetch accepts it
      REDIRECT: begin
        if (redirect_ready) begin
          state_n = IDLE;
        end else begin
          busy_n           = 1'b1;
          redirect_valid_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cause_q        <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q         <= '0;
`endif
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      busy           <= 1'b0;
      flush          <= 1'b0;
      trap_taken     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_n;
      cause_q        <= cause_n;
`ifdef TRAP_MTVAL_EN
      tval_q         <= tval_n;
`endif
      csr_we         <= csr_we_n;
      csr_waddr      <= csr_waddr_n;
      csr_wdata      <= csr_wdata_n;
      busy           <= busy_n;
      flush          <= flush_n;
      trap_taken     <= trap_taken_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer. Expected CSR writes are
// queued when an event is driven and checked in order by a monitor that
// samples on the falling edge; cycle timing is checked inline.
module tb_trap_sequencer;

  localparam int unsigned XLEN = 32;
`ifdef TRAP_MTVAL_EN
  localparam int TRAP_LAT = 5;
  localparam bit HAS_MTVAL = 1'b1;
`else
  localparam int TRAP_LAT = 4;
  localparam bit HAS_MTVAL = 1'b0;
`endif

  typedef struct packed {
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
  } csr_wr_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wb_retire;
  logic [XLEN-1:0] wb_next_pc;
  logic            wb_exception;
  logic [3:0]      wb_ecause;
  logic [XLEN-1:0] wb_epc;
  logic [XLEN-1:0] wb_tval;
  logic            wb_mret;
  logic [2:0]      irq_pending;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] mret_vector;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            busy;
  logic            flush;
  logic            trap_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  int errors = 0;
  int checks = 0;
  csr_wr_t exp_q[$];

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wb_retire      (wb_retire),
    .wb_next_pc     (wb_next_pc),
    .wb_exception   (wb_exception),
    .wb_ecause      (wb_ecause),
    .wb_epc         (wb_epc),
    .wb_tval        (wb_tval),
    .wb_mret        (wb_mret),
    .irq_pending    (irq_pending),
    .mstatus        (mstatus),
    .trap_vector    (trap_vector),
    .mret_vector    (mret_vector),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .busy           (busy),
    .flush          (flush),
    .trap_taken     (trap_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] trap_ms(input logic [XLEN-1:0] m);
    trap_ms = (m & ~32'h0000_1888) | (((m >> 3) & 32'h1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [XLEN-1:0] mret_ms(input logic [XLEN-1:0] m);
    mret_ms = (m & ~32'h0000_1888) | (((m >> 7) & 32'h1) << 3) | 32'h0000_1880;
  endfunction

  task automatic push(input logic [11:0] a, input logic [XLEN-1:0] d);
    csr_wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_trap(input logic [XLEN-1:0] epc, input logic [XLEN-1:0] cause,
                          input logic [XLEN-1:0] tval, input logic [XLEN-1:0] ms);
    push(12'h341, epc);
    push(12'h342, cause);
    if (HAS_MTVAL) push(12'h343, tval);
    push(12'h300, trap_ms(ms));
  endtask

  // Scoreboard: every CSR write must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n && csr_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_csr_write", {52'h0, csr_waddr}, 64'h0);
      end else begin
        csr_wr_t e;
        e = exp_q.pop_front();
        chk("csr_waddr", {52'h0, csr_waddr}, {52'h0, e.addr});
        chk("csr_wdata", {32'h0, csr_wdata}, {32'h0, e.data});
      end
    end
  end

  // Run a trap from cycle T (event already driven) through the handshake
  task automatic trap_flow(input string tag, input bit keep_irq, input logic [XLEN-1:0] vec);
    step();
    chk({tag, "_flush_t1"}, {63'h0, flush}, 64'h1);
    chk({tag, "_busy_t1"}, {63'h0, busy}, 64'h1);
    wb_exception = 1'b0;
    wb_mret = 1'b0;
    if (!keep_irq) irq_pending = 3'b000;
    for (int k = 2; k <= TRAP_LAT; k++) begin
      step();
      chk({tag, "_flush_off"}, {63'h0, flush}, 64'h0);
      chk({tag, "_busy"}, {63'h0, busy}, 64'h1);
      chk({tag, "_trap_taken"}, {63'h0, trap_taken}, {63'h0, (k == TRAP_LAT - 1)});
      chk({tag, "_rvalid"}, {63'h0, redirect_valid}, {63'h0, (k == TRAP_LAT)});
    end
    chk({tag, "_rpc"}, {32'h0, redirect_pc}, {32'h0, vec});
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk({tag, "_busy_done"}, {63'h0, busy}, 64'h0);
    chk({tag, "_rvalid_done"}, {63'h0, redirect_valid}, 64'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    wb_retire = 1'b0;
    wb_next_pc = '0;
    wb_exception = 1'b0;
    wb_ecause = '0;
    wb_epc = '0;
    wb_tval = '0;
    wb_mret = 1'b0;
    irq_pending = 3'b000;
    mstatus = '0;
    trap_vector = 32'h8000_0040;
    mret_vector = 32'h0000_0300;
    redirect_ready = 1'b0;
    step();
    step();
    chk("reset_outputs", {57'h0, csr_we, busy, flush, trap_taken, redirect_valid, 2'b00}, 64'h0);
    chk("reset_rpc", {32'h0, redirect_pc}, 64'h0);
    reset_n = 1'b1;
    step();

    // Exception trap
    mstatus = 32'h8;
    wb_exception = 1'b1;
    wb_ecause = 4'd2;
    wb_epc = 32'h100;
    wb_tval = 32'hDEAD;
    exp_trap(32'h100, 32'h2, 32'hDEAD, 32'h8);
    trap_flow("exc", 1'b0, 32'h8000_0040);
    chk("exc_trap_ms", {32'h0, trap_ms(32'h8)}, 64'h1880);

    // Interrupt: sip+tip pending, MSI wins
    wb_retire = 1'b1;
    wb_next_pc = 32'h204;
    irq_pending = 3'b011;
    exp_trap(32'h204, 32'h8000_0003, 32'h0, 32'h8);
    trap_flow("irq_msi", 1'b0, 32'h8000_0040);

    // Interrupt: all pending, MEI wins
    wb_next_pc = 32'h208;
    irq_pending = 3'b111;
    exp_trap(32'h208, 32'h8000_000B, 32'h0, 32'h8);
    trap_flow("irq_mei", 1'b0, 32'h8000_0040);

    // Interrupt with MIE clear: nothing happens
    mstatus = 32'h0;
    irq_pending = 3'b100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mie0_busy", {63'h0, busy}, 64'h0);
      chk("mie0_flush", {63'h0, flush}, 64'h0);
    end
    irq_pending = 3'b000;

    // Exception with tip pending: exception first, then the interrupt
    mstatus = 32'h8;
    wb_exception = 1'b1;
    wb_ecause = 4'd5;
    wb_epc = 32'h400;
    wb_tval = 32'h11;
    wb_next_pc = 32'h404;
    irq_pending = 3'b001;
    exp_trap(32'h400, 32'h5, 32'h11, 32'h8);
    trap_flow("exc_vs_irq", 1'b1, 32'h8000_0040);
    exp_trap(32'h404, 32'h8000_0007, 32'h0, 32'h8);
    trap_flow("irq_after_exc", 1'b0, 32'h8000_0040);

    // Exception with mret: exception wins
    wb_exception = 1'b1;
    wb_ecause = 4'd3;
    wb_epc = 32'h500;
    wb_tval = 32'h0;
    wb_mret = 1'b1;
    exp_trap(32'h500, 32'h3, 32'h0, 32'h8);
    trap_flow("exc_vs_mret", 1'b0, 32'h8000_0040);

    // mret with a long-stalled redirect
    mstatus = 32'h1880;
    wb_mret = 1'b1;
    push(12'h300, mret_ms(32'h1880));
    chk("mret_ms_model", {32'h0, mret_ms(32'h1880)}, 64'h1888);
    step();
    chk("mret_flush", {63'h0, flush}, 64'h1);
    chk("mret_busy", {63'h0, busy}, 64'h1);
    wb_mret = 1'b0;
    step();
    chk("mret_rvalid", {63'h0, redirect_valid}, 64'h1);
    chk("mret_rpc", {32'h0, redirect_pc}, 64'h300);
    chk("mret_trap_taken", {63'h0, trap_taken}, 64'h0);
    mret_vector = 32'hBAD0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_rvalid", {63'h0, redirect_valid}, 64'h1);
      chk("hold_rpc", {32'h0, redirect_pc}, 64'h300);
      chk("hold_busy", {63'h0, busy}, 64'h1);
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("mret_busy_done", {63'h0, busy}, 64'h0);
    chk("mret_rvalid_done", {63'h0, redirect_valid}, 64'h0);

    // Reset in the middle of a trap
    mstatus = 32'h8;
    wb_exception = 1'b1;
    wb_ecause = 4'd7;
    wb_epc = 32'h600;
    push(12'h341, 32'h600);
    step();
    chk("rst_flush_t1", {63'h0, flush}, 64'h1);
    wb_exception = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {58'h0, csr_we, busy, flush, trap_taken, redirect_valid, 1'b0}, 64'h0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_busy", {63'h0, busy}, 64'h0);
      chk("post_rst_we", {63'h0, csr_we}, 64'h0);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
